// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and buffered load returns
// onto the one register file write port, with strict ALU priority.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_rd,
  input  logic [XLEN-1:0]          ld_data,
  output logic                     we,
  output logic [4:0]               rd,
  output logic [XLEN-1:0]          wdata,
  output logic                     alu_stall,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Load handshake: a load transfers on a posedge where ld_valid && ld_ready;
  // ld_valid may not depend on ld_ready, and ld_ready never depends on ld_valid.
  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  // Flow control comes from registered count only, so a pop while full does
  // not reopen ld_ready until the next cycle.
  assign ld_ready  = (count != CW'(DEPTH));
  assign alu_stall = (count == CW'(DEPTH));
  assign push      = ld_valid && ld_ready;
  assign pop       = !alu_valid && (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= ld_rd;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Writes to x0 are consumed and registered but never enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we    <= 1'b0;
      rd    <= '0;
      wdata <= '0;
    end else if (alu_valid) begin
      we    <= (alu_rd != 5'd0);
      rd    <= alu_rd;
      wdata <= alu_data;
    end else if (pop) begin
      we    <= (fifo_rd[rd_ptr] != 5'd0);
      rd    <= fifo_rd[rd_ptr];
      wdata <= fifo_data[rd_ptr];
    end else begin
      we    <= 1'b0;
    end
  end

  // Upstream must hold off ALU results while the FIFO is full.
  alu_while_stalled: assert property (@(posedge clk) disable iff (!reset)
    !(alu_valid && alu_stall));

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a random phase,
// all checked against a queue-based behavioural model and write scoreboard.
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int W     = 5 + XLEN;

  logic            clk;
  logic            reset;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            we;
  logic [4:0]      rd;
  logic [XLEN-1:0] wdata;
  logic            alu_stall;
  logic [CW-1:0]   count;

  wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .we(we), .rd(rd), .wdata(wdata),
    .alu_stall(alu_stall), .count(count)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and model state
  logic [W-1:0]    exp_q[$];
  logic [W-1:0]    m_fifo[$];
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_wdata;
  logic            m_we;
  int              n_cmp;
  int              n_err;

  task automatic model_reset();
    exp_q.delete();
    m_fifo.delete();
    m_rd    = '0;
    m_wdata = '0;
    m_we    = 1'b0;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    ld_valid  = 1'b0;
    ld_rd     = '0;
    ld_data   = '0;
  endtask

  // Advance one edge: update the model from the inputs now applied, push the
  // expected write, then compare every output #1 after the edge.
  task automatic cycle(input string tag);
    logic [W-1:0] e;
    logic [W-1:0] got;
    logic         accept;
    accept = ld_valid && (m_fifo.size() < DEPTH);
    m_we = 1'b0;
    if (alu_valid) begin
      m_rd = alu_rd; m_wdata = alu_data; m_we = (alu_rd != 5'd0);
    end else if (m_fifo.size() > 0) begin
      e = m_fifo.pop_front();
      m_rd = e[W-1:XLEN]; m_wdata = e[XLEN-1:0]; m_we = (m_rd != 5'd0);
    end
    if (m_we) exp_q.push_back({m_rd, m_wdata});
    if (accept) m_fifo.push_back({ld_rd, ld_data});
    @(posedge clk);
    #1;
    n_cmp++;
    if (we !== m_we) begin
      n_err++; $display("FAIL %s we: got %b expected %b", tag, we, m_we);
    end
    if (we === 1'b1) begin
      n_cmp++;
      got = {rd, wdata};
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL %s write: got rd=%0d wdata=%h expected no write", tag, rd, wdata);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL %s write: got rd=%0d wdata=%h expected rd=%0d wdata=%h",
                   tag, rd, wdata, e[W-1:XLEN], e[XLEN-1:0]);
        end
      end
    end
    n_cmp++;
    if (rd !== m_rd || wdata !== m_wdata) begin
      n_err++;
      $display("FAIL %s rd/wdata: got %0d/%h expected %0d/%h", tag, rd, wdata, m_rd, m_wdata);
    end
    n_cmp++;
    if (count !== CW'(m_fifo.size())) begin
      n_err++; $display("FAIL %s count: got %0d expected %0d", tag, count, m_fifo.size());
    end
    n_cmp++;
    if (ld_ready !== (m_fifo.size() != DEPTH) || alu_stall !== (m_fifo.size() == DEPTH)) begin
      n_err++;
      $display("FAIL %s flow: got ld_ready=%b alu_stall=%b expected %b/%b", tag, ld_ready,
               alu_stall, m_fifo.size() != DEPTH, m_fifo.size() == DEPTH);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (we !== 1'b0 || rd !== 5'd0 || wdata !== '0) begin
      n_err++; $display("FAIL reset outputs: got we=%b rd=%0d wdata=%h expected 0/0/0", we, rd, wdata);
    end
    n_cmp++;
    if (count !== '0 || ld_ready !== 1'b1 || alu_stall !== 1'b0) begin
      n_err++;
      $display("FAIL reset flow: got count=%0d ld_ready=%b alu_stall=%b expected 0/1/0",
               count, ld_ready, alu_stall);
    end
    @(negedge clk);
    reset = 1'b1;
    cycle("reset_idle");
  endtask

  task automatic test_alu_only();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    cycle("alu_only");
    n_cmp++;
    if (we !== 1'b1 || rd !== 5'd5 || wdata !== 32'hDEADBEEF || count !== '0) begin
      n_err++; $display("FAIL alu_only direct: got we=%b rd=%0d wdata=%h count=%0d expected 1/5/deadbeef/0",
                        we, rd, wdata, count);
    end
    idle_inputs();
    cycle("alu_only_after");
  endtask

  task automatic test_load_only();
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234;
    cycle("load_enq");
    n_cmp++;
    if (count !== CW'(1) || we !== 1'b0) begin
      n_err++; $display("FAIL load_enq direct: got count=%0d we=%b expected 1/0", count, we);
    end
    idle_inputs();
    cycle("load_deq");
    n_cmp++;
    if (we !== 1'b1 || rd !== 5'd7 || wdata !== 32'h1234 || count !== '0) begin
      n_err++; $display("FAIL load_deq direct: got we=%b rd=%0d wdata=%h count=%0d expected 1/7/1234/0",
                        we, rd, wdata, count);
    end
    cycle("load_idle");
  endtask

  task automatic test_priority();
    ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'hA1;
    cycle("prio_e1");
    ld_rd = 5'd2; ld_data = 32'hA2;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hC3;
    cycle("prio_e2");
    ld_valid = 1'b0; alu_data = 32'hC4;
    cycle("prio_e3");
    idle_inputs();
    cycle("prio_e4");
    n_cmp++;
    if (rd !== 5'd1 || wdata !== 32'hA1) begin
      n_err++; $display("FAIL prio_order: got rd=%0d wdata=%h expected 1/a1", rd, wdata);
    end
    cycle("prio_e5");
    cycle("prio_e6");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'(i * 32'h1111_0000 + 1);
      cycle("b2b");
    end
    idle_inputs();
    cycle("b2b_end");
  endtask

  task automatic test_full();
    alu_valid = 1'b1; alu_rd = 5'd9;
    for (int i = 0; i < DEPTH; i++) begin
      alu_data = 32'(100 + i);
      ld_valid = 1'b1; ld_rd = 5'(16 + i); ld_data = 32'(32'hF000 + i);
      cycle("full_fill");
    end
    n_cmp++;
    if (count !== CW'(DEPTH) || ld_ready !== 1'b0 || alu_stall !== 1'b1) begin
      n_err++; $display("FAIL full_state: got count=%0d ld_ready=%b alu_stall=%b expected %0d/0/1",
                        count, ld_ready, alu_stall, DEPTH);
    end
    alu_valid = 1'b0;
    ld_rd = 5'd20; ld_data = 32'hBAD0;
    cycle("full_reject");
    n_cmp++;
    if (count !== CW'(DEPTH - 1) || ld_ready !== 1'b1) begin
      n_err++; $display("FAIL full_reopen: got count=%0d ld_ready=%b expected %0d/1",
                        count, ld_ready, DEPTH - 1);
    end
    idle_inputs();
    repeat (DEPTH) cycle("full_drain");
  endtask

  task automatic test_x0();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    cycle("x0_alu");
    n_cmp++;
    if (we !== 1'b0 || rd !== 5'd0 || wdata !== 32'hFFFFFFFF) begin
      n_err++; $display("FAIL x0_alu direct: got we=%b rd=%0d wdata=%h expected 0/0/ffffffff", we, rd, wdata);
    end
    idle_inputs();
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h55;
    cycle("x0_ld_enq");
    idle_inputs();
    cycle("x0_ld_deq");
    cycle("x0_ld_idle");
  endtask

  task automatic test_reset_mid();
    alu_valid = 1'b1; alu_rd = 5'd9;
    for (int i = 0; i < 3; i++) begin
      alu_data = 32'(200 + i);
      ld_valid = 1'b1; ld_rd = 5'(24 + i); ld_data = 32'(32'hE000 + i);
      cycle("rst_fill");
    end
    #3;
    reset = 1'b0;
    idle_inputs();
    #1;
    n_cmp++;
    if (we !== 1'b0 || count !== '0 || ld_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_async: got we=%b count=%0d ld_ready=%b expected 0/0/1",
                        we, count, ld_ready);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (DEPTH + 1) cycle("rst_after");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      alu_valid = (m_fifo.size() < DEPTH) && ($urandom_range(0, 99) < 40);
      alu_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 99) < 55);
      ld_rd     = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ld_data   = $urandom;
      cycle("random");
    end
    idle_inputs();
    repeat (DEPTH + 1) cycle("random_drain");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_alu_only();
    test_load_only();
    test_priority();
    test_back_to_back();
    test_full();
    test_x0();
    test_reset_mid();
    test_random();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL leftover_writes: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the execute/memory stages and the register file write port. Merges single-cycle ALU results and variable-latency load returns onto the one `we/rd/wdata` port. Buffers load returns in a small FIFO. Gives the ALU path strict priority.

## Interface
Parameters:
- `DEPTH`, 4: load-return FIFO entries; power of two, at least 2.
- `XLEN`, 32: data width.

Ports:
- `clk`  in  1  clock; all state changes at posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result present this cycle; never back-pressured.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `ld_valid`  in  1  load return offered.
- `ld_ready`  out  1  FIFO can accept a load; high when the FIFO is not full.
- `ld_rd`  in  5  load destination register.
- `ld_data`  in  XLEN  load data.
- `we`  out  1  register file write enable (registered).
- `rd`  out  5  register file write address (registered).
- `wdata`  out  XLEN  register file write data (registered).
- `alu_stall`  out  1  FIFO full; upstream must hold off new ALU results.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- The FIFO is a circular buffer with write pointer, read pointer and occupancy counter.
  - Pointers wrap modulo DEPTH.
  - `count` ranges 0..DEPTH.
- A load is enqueued at a posedge when `ld_valid && ld_ready`. There is no bypass: a load always passes through the FIFO.
- Selection at each posedge, in priority order:
  1. `alu_valid` = 1: the output registers take `alu_rd`/`alu_data`; the FIFO does not dequeue.
  2. Otherwise, if `count` > 0: the FIFO head is dequeued into the output registers.
  3. Otherwise: `we` = 0. `rd` and `wdata` hold their previous values.
- x0 suppression: a selected entry with destination 0 drives `we` = 0.
  - The entry is still consumed (ALU accepted, or FIFO popped).
  - `rd` = 0 and `wdata` = the data are still registered.
- Simultaneous enqueue and dequeue in one cycle: `count` is unchanged; both pointers advance.
- Flow control:
  - `ld_ready` = (`count` != DEPTH).
  - `alu_stall` = (`count` == DEPTH).
  - Both are combinational from registered `count`.
- When full and a dequeue happens, `ld_ready` stays 0 that cycle. The freed slot is visible the next cycle.
- Ordering:
  - Loads leave in arrival order.
  - An ALU result may overtake older buffered loads. Upstream hazard logic prevents a same-`rd` conflict.
- If `alu_valid` is asserted while `alu_stall` = 1, the ALU still wins. Upstream is required never to do this; assertion only.
- Reset (`reset` = 0, asynchronous):
  - Pointers and `count` go to 0.
  - `we` = 0, `rd` = 0, `wdata` = 0.
  - `ld_ready` = 1, `alu_stall` = 0.
- Reset mid-operation discards all buffered loads with no partial write. `we` drops immediately and asynchronously.

## Timing
- ALU latency: sampled at edge N; `we`/`rd`/`wdata` valid after edge N, for one cycle.
- Load latency, empty FIFO, no ALU traffic:
  - enqueued at edge N;
  - dequeued at edge N+1;
  - `we` high after edge N+1.
  - Minimum 2 edges.
- Sustained throughput: one register file write per cycle. With continuous ALU traffic, loads are held until the first ALU-idle cycle.
- `we` is a single-cycle pulse per selected entry. Back-to-back writes keep `we` high.
- The register file writes on the edge after `we` is presented. `wb_arbiter` outputs are stable for a full cycle before that edge.
- Release of reset is synchronous to `clk` upstream; the first usable edge is the one after deassertion.

## Test plan
- ALU only: `alu_valid`=1, `alu_rd`=5, `alu_data`=0xDEADBEEF at edge 1 -> after edge 1, `we`=1, `rd`=5, `wdata`=0xDEADBEEF; `count`=0.
- Load only: `ld_rd`=7, `ld_data`=0x1234 at edge 1 -> `count`=1 after edge 1; `we`=1, `rd`=7, `wdata`=0x1234 after edge 2; `count`=0.
- Priority/ordering:
  - stimulus: loads to x1, x2 at edges 1–2, then ALU to x3 valid at edges 2–3;
  - output order: x3 (edge 2), x3 (edge 3), x1 (edge 4), x2 (edge 5).
- Full: enqueue 4 loads with `alu_valid`=1 held to x9 -> `count`=4, `ld_ready`=0, `alu_stall`=1; a 5th `ld_valid` is not accepted. Drop `alu_valid` -> one pop per cycle; `ld_ready` returns to 1 the cycle after the first pop.
- x0: ALU write to `rd`=0, `data`=0xFFFFFFFF -> `we`=0 the following cycle; a later read of x0 returns 0.
- Reset: with `count`=3 and `we`=1, assert `reset`=0 mid-cycle -> `we`=0 immediately. `count`=0 and `ld_ready`=1 after deassertion; no buffered load is ever written.
